// File: rtl/adder32_pkg.sv
// -----------------------------------------------------------------------------
// adder32_pkg
// Shared definitions for the registered 32-bit adder: operand width, word type,
// the status-flag record and the helper that derives the flags from a
// WIDTH+1-bit sum.
// Optional feature macro: ADDER32_FLAGS_EN (flags are only consumed when set).
// -----------------------------------------------------------------------------
package adder32_pkg;

   localparam int ADDER32_WIDTH = 32;

   typedef logic [ADDER32_WIDTH-1:0] word_t;

   typedef struct packed {
      logic carry;
      logic overflow;
      logic zero;
   } flags_t;

   localparam flags_t FLAGS_RESET = '{carry: 1'b0, overflow: 1'b0, zero: 1'b0};

   // Flags of a + b given the carry-extended sum.
   // Signed overflow: operands share a sign that the result does not.
   function automatic flags_t calc_flags(input word_t a,
                                         input word_t b,
                                         input logic [ADDER32_WIDTH:0] sum_ext);
      flags_t f;
      f.carry    = sum_ext[ADDER32_WIDTH];
      f.overflow = (a[ADDER32_WIDTH-1] == b[ADDER32_WIDTH-1]) &&
                   (sum_ext[ADDER32_WIDTH-1] != a[ADDER32_WIDTH-1]);
      f.zero     = (sum_ext[ADDER32_WIDTH-1:0] == {ADDER32_WIDTH{1'b0}});
      return f;
   endfunction

endpackage

// File: rtl/adder32_comb.sv
// -----------------------------------------------------------------------------
// adder32_comb
// Purely combinational modulo-2^32 sum of two words. With ADDER32_FLAGS_EN the
// sum is formed at WIDTH+1 bits and carry/overflow/zero are derived from it.
// Ports:
//   a, b   in   word_t   operands
//   sum    out  word_t   (a + b) mod 2^32
//   flags  out  flags_t  carry/overflow/zero (only with ADDER32_FLAGS_EN)
// -----------------------------------------------------------------------------
module adder32_comb
   import adder32_pkg::*;
(
   input  word_t  a,
   input  word_t  b,
   output word_t  sum
`ifdef ADDER32_FLAGS_EN
   ,
   output flags_t flags
`endif
);

`ifdef ADDER32_FLAGS_EN
   logic [ADDER32_WIDTH:0] sum_ext_s;

   // Carry-extended sum and the flags derived from it.
   always_comb begin
      sum_ext_s = {1'b0, a} + {1'b0, b};
      sum       = sum_ext_s[ADDER32_WIDTH-1:0];
      flags     = calc_flags(a, b, sum_ext_s);
   end
`else
   // Plain wrapping sum; the carry-out has no consumer without flags.
   always_comb begin
      sum = a + b;
   end
`endif

endmodule

// File: rtl/adder32.sv
// -----------------------------------------------------------------------------
// adder32
// Registered 32-bit two's-complement adder, one-cycle latency, one operation
// per cycle, no back-pressure. Result (and optional flags) load only when
// in_valid is high and otherwise hold, so operand values while idle never
// reach the output.
// Optional feature macro: ADDER32_FLAGS_EN adds carry/overflow/zero outputs.
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-high reset
//   in_valid   in   1      new operation on in1/in2 this cycle
//   in1, in2   in   WIDTH  operands
//   out        out  WIDTH  registered sum mod 2^WIDTH
//   out_valid  out  1      one-cycle pulse per new sum
//   carry      out  1      unsigned carry-out   (ADDER32_FLAGS_EN)
//   overflow   out  1      signed overflow      (ADDER32_FLAGS_EN)
//   zero       out  1      sum equals zero      (ADDER32_FLAGS_EN)
// -----------------------------------------------------------------------------
module adder32
   import adder32_pkg::*;
#(
   parameter int WIDTH = ADDER32_WIDTH
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic [WIDTH-1:0] out,
   output logic             out_valid
`ifdef ADDER32_FLAGS_EN
   ,
   output logic             carry,
   output logic             overflow,
   output logic             zero
`endif
);

   word_t sum_s;
   word_t out_q;
   word_t out_d;
   logic  out_valid_q;
   logic  out_valid_d;

`ifdef ADDER32_FLAGS_EN
   flags_t flags_s;
   flags_t flags_q;
   flags_t flags_d;

   adder32_comb u_comb (
      .a     (in1),
      .b     (in2),
      .sum   (sum_s),
      .flags (flags_s)
   );

   // Next-state for result, flags and valid: load on in_valid, else hold.
   always_comb begin
      out_d       = out_q;
      flags_d     = flags_q;
      out_valid_d = 1'b0;
      if (in_valid) begin
         out_d       = sum_s;
         flags_d     = flags_s;
         out_valid_d = 1'b1;
      end else begin
         out_d       = out_q;
         flags_d     = flags_q;
         out_valid_d = 1'b0;
      end
   end

   // Output registers; reset clears everything and takes priority over in_valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q       <= {ADDER32_WIDTH{1'b0}};
         flags_q     <= FLAGS_RESET;
         out_valid_q <= 1'b0;
      end else begin
         out_q       <= out_d;
         flags_q     <= flags_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign carry    = flags_q.carry;
   assign overflow = flags_q.overflow;
   assign zero     = flags_q.zero;
`else
   adder32_comb u_comb (
      .a   (in1),
      .b   (in2),
      .sum (sum_s)
   );

   // Next-state for result and valid: load on in_valid, else hold.
   always_comb begin
      out_d       = out_q;
      out_valid_d = 1'b0;
      if (in_valid) begin
         out_d       = sum_s;
         out_valid_d = 1'b1;
      end else begin
         out_d       = out_q;
         out_valid_d = 1'b0;
      end
   end

   // Output registers; reset clears everything and takes priority over in_valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q       <= {ADDER32_WIDTH{1'b0}};
         out_valid_q <= 1'b0;
      end else begin
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end
`endif

   assign out       = out_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_adder32.sv
// -----------------------------------------------------------------------------
// tb_adder32
// Self-checking bench for adder32: a table of operand/expected-result records
// applied back to back, hand-written hold and reset sequences, and a short
// random run. Expected results go into a scoreboard queue when an operation is
// driven and are popped when the registered result is due.
// Flag checks are compiled in with ADDER32_FLAGS_EN.
// -----------------------------------------------------------------------------
module tb_adder32;
   import adder32_pkg::*;

   typedef struct {
      word_t in1;
      word_t in2;
      word_t out;
      logic  c;
      logic  o;
      logic  z;
   } vec_t;

   typedef struct {
      word_t out;
      logic  c;
      logic  o;
      logic  z;
   } exp_t;

   logic  clk = 1'b0;
   logic  rst = 1'b0;
   logic  in_valid = 1'b0;
   word_t in1 = '0;
   word_t in2 = '0;
   word_t out;
   logic  out_valid;
`ifdef ADDER32_FLAGS_EN
   logic  carry;
   logic  overflow;
   logic  zero;
`endif

   int    n_checks = 0;
   int    n_errors = 0;
   exp_t  sb_q[$];
   exp_t  last_exp;
   vec_t  vecs[9];

   adder32 dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in1       (in1),
      .in2       (in2),
      .out       (out),
      .out_valid (out_valid)
`ifdef ADDER32_FLAGS_EN
      ,
      .carry     (carry),
      .overflow  (overflow),
      .zero      (zero)
`endif
   );

   always #5 clk = ~clk;

   task automatic check_word(input string name, input word_t act, input word_t exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic check_outputs(input string name, input logic exp_valid, input exp_t e);
      check_bit({name, ".out_valid"}, out_valid, exp_valid);
      check_word({name, ".out"}, out, e.out);
`ifdef ADDER32_FLAGS_EN
      check_bit({name, ".carry"}, carry, e.c);
      check_bit({name, ".overflow"}, overflow, e.o);
      check_bit({name, ".zero"}, zero, e.z);
`endif
   endtask

   // One clock cycle: drive at the falling edge, check just after the rising edge.
   task automatic step(input string name, input logic v, input word_t a, input word_t b,
                       input exp_t e);
      exp_t got;
      @(negedge clk);
      in_valid = v;
      in1      = a;
      in2      = b;
      if (v) sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (v) begin
         n_checks++;
         if (sb_q.size() == 0) begin
            n_errors++;
            $display("FAIL %s.scoreboard: got empty queue expected entry", name);
            got = last_exp;
         end else begin
            got = sb_q.pop_front();
         end
         last_exp = got;
      end
      check_outputs(name, v, last_exp);
   endtask

   function automatic exp_t model(input word_t a, input word_t b);
      logic [32:0] full;
      exp_t        e;
      full  = {1'b0, a} + {1'b0, b};
      e.out = full[31:0];
      e.c   = full[32];
      e.o   = (a[31] == b[31]) && (full[31] != a[31]);
      e.z   = (full[31:0] == 32'h0000_0000);
      return e;
   endfunction

   function automatic exp_t to_exp(input vec_t v);
      exp_t e;
      e.out = v.out;
      e.c   = v.c;
      e.o   = v.o;
      e.z   = v.z;
      return e;
   endfunction

   initial begin
      exp_t zero_exp;
      exp_t dummy;
      zero_exp = '{out: 32'h0000_0000, c: 1'b0, o: 1'b0, z: 1'b0};
      dummy    = zero_exp;
      last_exp = zero_exp;

      vecs[0] = '{32'h0000_4040, 32'h0004_400F, 32'h0004_804F, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{32'h0000_000F, 32'h0000_000F, 32'h0000_001E, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
      vecs[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
      vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0};
      vecs[6] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
      vecs[7] = '{32'h1234_5678, 32'h8765_4321, 32'h9999_9999, 1'b0, 1'b0, 1'b0};
      vecs[8] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1};

      // Async reset with live operands, checked before any rising edge.
      in_valid = 1'b1;
      in1      = 32'hDEAD_BEEF;
      in2      = 32'h1234_5678;
      #1 rst = 1'b1;
      #1;
      check_outputs("reset_async", 1'b0, zero_exp);
      @(negedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      rst      = 1'b0;

      // Table vectors, back to back.
      for (int i = 0; i < 9; i++) begin
         step($sformatf("vec%0d", i), 1'b1, vecs[i].in1, vecs[i].in2, to_exp(vecs[i]));
      end

      // Small add then hold with changing and unknown operands.
      step("add15", 1'b1, 32'd15, 32'd15, to_exp(vecs[1]));
      step("hold1", 1'b0, 32'hAAAA_5555, 32'h0F0F_F0F0, dummy);
      step("hold2", 1'b0, 'x, 'x, dummy);
      check_word("hold_value", out, 32'd30);

      // Three back-to-back ops, reset during the second.
      step("pipe_a", 1'b1, 32'h0000_1000, 32'h0000_0234, model(32'h0000_1000, 32'h0000_0234));
      @(negedge clk);
      in_valid = 1'b1;
      in1      = 32'h0000_2000;
      in2      = 32'h0000_0001;
      #2 rst = 1'b1;
      #1;
      check_outputs("pipe_rst_imm", 1'b0, zero_exp);
      @(posedge clk);
      #1;
      check_outputs("pipe_rst_edge", 1'b0, zero_exp);
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
      last_exp = zero_exp;
      step("pipe_c", 1'b1, 32'h0000_3000, 32'h0000_0003, model(32'h0000_3000, 32'h0000_0003));

      // Random operands with occasional idle cycles.
      for (int i = 0; i < 40; i++) begin
         word_t a;
         word_t b;
         logic  v;
         a = $urandom();
         b = $urandom();
         v = ($urandom_range(3, 0) != 0);
         step($sformatf("rand%0d", i), v, a, b, model(a, b));
      end

      @(negedge clk);
      in_valid = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
